divider_controller: RTL

- Runtime-programmable clock-divider controller for iCE40UP5K designs. Shares one divide counter, and lets a host change the half-period or start/stop the output over a valid/ready handshake.
- Changes and stops take effect only on an output falling boundary, so the divided output never glitches and never emits a runt pulse.
- Drives LED blink, PWM and peripheral clock enables from the 48 MHz HFOSC domain.

---
 rtl/divider_controller_pkg.sv | 18 +
 rtl/div_counter.sv | 41 ++++
 rtl/divider_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/divider_controller_pkg.sv
// Shared definitions for the programmable clock-divider controller.
package divider_controller_pkg;

    localparam int HFOSC_HZ = 48_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_e;

    // Half-period in HFOSC cycles for a requested output frequency.
    function automatic int half_for_hz(input int out_hz);
        return HFOSC_HZ / (2 * out_hz);
    endfunction

endpackage

// File: rtl/div_counter.sv
// Loadable down-counter with a registered terminal-count (zero) flag.
module div_counter #(
    parameter int           W         = 16,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         zero_q;

    // Next count: load wins over decrement, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register and zero flag registered together so they never disagree.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= RESET_VAL;
            zero_q <= (RESET_VAL == '0);
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/divider_controller.sv
// Runtime-programmable clock divider; half-period changes and stops are
// deferred to an out_clk falling boundary so the output never glitches.
//
// state | meaning
// IDLE  | out_clk held low, timer parked at half-1, waiting for enable
// RUN   | dividing with the current half-period
// PEND  | dividing; new half-period waits for the next falling boundary
// STOP  | enable dropped; finish to the next falling boundary, then IDLE
module divider_controller
    import divider_controller_pkg::*;
#(
    parameter int HALF_W       = 16,
    parameter int DEFAULT_HALF = half_for_hz(1000)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              cfg_valid,
    input  logic [HALF_W-1:0] cfg_half,
    output logic              cfg_ready,
    output logic              out_clk,
    output logic              tick,
    output logic              running
);

    localparam logic [HALF_W-1:0] DEF_HALF = HALF_W'(DEFAULT_HALF);
    localparam logic [HALF_W-1:0] ONE      = HALF_W'(1);

    state_e            state_q, state_d;
    logic              out_clk_q, out_clk_d;
    logic              tick_q, tick_d;
    logic              cfg_ready_q, running_q;
    logic [HALF_W-1:0] half_q, half_d;
    logic [HALF_W-1:0] pend_q, pend_d;

    logic              tmr_zero, tmr_load, tmr_dec;
    logic [HALF_W-1:0] tmr_val;
    logic              xfer, bnd, fall;

    div_counter #(
        .W         (HALF_W),
        .RESET_VAL (DEF_HALF - ONE)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Next-state, boundary handling and timer control.
    always_comb begin
        state_d   = state_q;
        out_clk_d = out_clk_q;
        tick_d    = 1'b0;
        half_d    = half_q;
        pend_d    = pend_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_val   = half_q - ONE;

        xfer = cfg_valid && cfg_ready_q;
        bnd  = tmr_zero && (state_q != IDLE);
        fall = bnd && out_clk_q;

        if (bnd) begin
            out_clk_d = ~out_clk_q;
            tick_d    = 1'b1;
            tmr_load  = 1'b1;
        end else if (state_q != IDLE) begin
            tmr_dec = 1'b1;
        end

        case (state_q)
            IDLE: begin
                out_clk_d = 1'b0;
                if (xfer) begin
                    half_d   = cfg_half;
                    tmr_load = 1'b1;
                    tmr_val  = cfg_half - ONE;
                end
                // A zero half-period parks the divider until a non-zero one arrives.
                if (enable && (half_d != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    pend_d  = cfg_half;
                    state_d = PEND;
                end else if (!enable) begin
                    state_d = STOP;
                end
            end
            PEND: begin
                if (fall) begin
                    half_d  = pend_q;
                    tmr_val = pend_q - ONE;
                    state_d = ((pend_q == '0) || !enable) ? IDLE : RUN;
                end
            end
            STOP: begin
                if (enable) begin
                    state_d = RUN;
                end else if (xfer) begin
                    pend_d  = cfg_half;
                    state_d = PEND;
                end else if (fall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_clk_q   <= 1'b0;
            tick_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            running_q   <= 1'b0;
            half_q      <= DEF_HALF;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_clk_q   <= out_clk_d;
            tick_q      <= tick_d;
            cfg_ready_q <= (state_d != PEND);
            running_q   <= (state_d == RUN) || (state_d == PEND);
            half_q      <= half_d;
            pend_q      <= pend_d;
        end
    end

    assign out_clk   = out_clk_q;
    assign tick      = tick_q;
    assign cfg_ready = cfg_ready_q;
    assign running   = running_q;

endmodule
